pixel_clk_gen: RTL
==================

// Module: pixel_clk_gen
// PURPOSE
//  Parametrised pixel-clock generator for the VGA pipeline. A fractional-N phase accumulator
//  clocked by sysClock emits a pixel clock-enable strobe averaging f_sys*INC/2^ACC_W.
//  Four run-time selectable modes, each with its own increment. A lock indicator qualifies
//  the strobe after a settle period. Downstream timing generators advance only on pix_stb.
// PARAMETERS
//  ACC_W        24          accumulator width (bits)
//  INC0         24'd8799300 mode 0 increment: 25.175 MHz from 48 MHz (640x480@60)
//  INC1         24'd4399650 mode 1 increment: 12.5875 MHz (half-rate 640x480)
//  INC2         24'h800000  mode 2 increment: 24 MHz (exact, every 2nd cycle)
//  INC3         24'h400000  mode 3 increment: 12 MHz (exact, every 4th cycle)
//  LOCK_STROBES 16          strobes counted after (re)start before lock asserts
//  DEFAULT_MODE 2'd0        mode loaded by reset
// PORTS
//  sysClock         in   1  system clock (48 MHz)
//  reset            in   1  asynchronous, active-low reset
//  mode_sel         in   2  requested mode; held stable while mode_req=1
//  mode_req         in   1  level request to switch to mode_sel
//  mode_ack         out  1  one-cycle pulse: request accepted
//  cur_mode         out  2  mode currently in effect
//  pix_stb          out  1  pixel clock enable (registered)
//  clk_pixel_locked out  1  strobe stream valid and settled
//  mode_err         out  1  current mode has INC==0 (sticky until next valid switch)
// BEHAVIOUR
//  Reset (reset=0, async): acc=0, lock_cnt=0, pix_stb=0, clk_pixel_locked=0, mode_ack=0,
//   mode_err=0, cur_mode=DEFAULT_MODE, inc=INC[DEFAULT_MODE], state=SETTLE. Effective mid-
//   operation immediately, any state; no request is remembered across reset.
//  Accumulator: each cycle {carry,acc} <= acc + inc (ACC_W+1-bit add, acc wraps mod 2^ACC_W);
//   pix_stb <= carry. Latency: first strobe one cycle after the carry-producing add.
//   inc < 2^ACC_W, so pix_stb may be high on consecutive cycles when ratio > 0.5 (mode 0).
//  FSM states: SETTLE, LOCKED, SWITCH.
//   SETTLE: lock_cnt increments on each cycle with pix_stb=1; on the cycle pix_stb=1 and
//    lock_cnt==LOCK_STROBES-1 -> LOCKED; clk_pixel_locked=1 from the next cycle.
//   LOCKED: clk_pixel_locked held 1; accumulator free-runs.
//   mode_req=1 in SETTLE or LOCKED -> SWITCH next cycle (same-mode requests also re-lock).
//   SWITCH (exactly 1 cycle): mode_ack=1; cur_mode<=mode_sel; inc<=INC[mode_sel]; acc<=0;
//    lock_cnt<=0; pix_stb<=0; clk_pixel_locked<=0; mode_err<=(INC[mode_sel]==0); -> SETTLE.
//    Requester drops mode_req on the ack cycle. mode_req still high the cycle after SWITCH
//    is a new request.
//  clk_pixel_locked falls in the cycle after the request is sampled (entering SWITCH).
//  INC==0 mode: no strobes, clk_pixel_locked stays 0, mode_err=1; next valid switch clears it.
//  Long-run strobe count over N cycles = floor(N*inc/2^ACC_W) +/-1, no drift.
// TESTING
//  1 Reset, default mode 0, run 48000 cycles -> 25174..25175 pix_stb pulses; never >2 misses
//    in a row; clk_pixel_locked=1 after 16th strobe.
//  2 mode_sel=2 req -> ack 1 cycle; pix_stb exactly every 2nd cycle; clk_pixel_locked rises
//    the cycle after the 16th strobe (~32 cycles after ack); cur_mode=2.
//  3 Locked in mode 2, request mode 3 -> clk_pixel_locked drops cycle after req sampled;
//    strobes every 4th cycle; relock after 16 strobes (~64 cycles).
//  4 INC1 overridden to 0, select mode 1 -> mode_err=1, zero strobes and locked=0 for 1000
//    cycles; then select mode 0 -> mode_err=0, normal relock.
//  5 Assert reset during SETTLE and during SWITCH -> all outputs 0 same cycle,
//    cur_mode=DEFAULT_MODE; after release relock in mode 0 within 35 cycles.
//  6 mode_req held 3 cycles past ack -> second SWITCH/ack occurs; lock restarts again.

Source files
------------

// File: rtl/pixel_clk_gen.sv
// -----------------------------------------------------------------------------
// pixel_clk_gen
//
// Fractional-N pixel clock-enable generator for the VGA pipeline.
//
// A phase accumulator clocked by sysClock adds the current mode's increment
// every cycle. The carry out of that add, registered, is pix_stb. The long-run
// strobe rate is therefore f_sys * inc / 2^ACC_W, with no drift.
//
// Four run-time selectable modes each have their own increment. A mode switch
// is a level request/pulse acknowledge handshake. Each switch restarts the
// accumulator and the lock qualifier. clk_pixel_locked asserts only after
// LOCK_STROBES strobes have been seen since the last (re)start.
//
// Ports
//   sysClock          in   system clock
//   reset             in   asynchronous, active-low reset
//   mode_sel[1:0]     in   requested mode, stable while mode_req is high
//   mode_req          in   level request to switch to mode_sel
//   mode_ack          out  one-cycle pulse, request accepted (SWITCH state)
//   cur_mode[1:0]     out  mode currently in effect
//   pix_stb           out  registered pixel clock enable
//   clk_pixel_locked  out  strobe stream valid and settled
//   mode_err          out  current mode has a zero increment (sticky until
//                          the next switch to a valid mode)
//
// FSM
//   state  | meaning
//   SETTLE | accumulator running, counting strobes toward lock
//   LOCKED | lock reached, accumulator free-runs, locked output high
//   SWITCH | one cycle: ack, load new mode, clear accumulator and lock count
// -----------------------------------------------------------------------------
module pixel_clk_gen #(
  parameter int               ACC_W        = 24,
  parameter logic [ACC_W-1:0] INC0         = 24'd8799300,
  parameter logic [ACC_W-1:0] INC1         = 24'd4399650,
  parameter logic [ACC_W-1:0] INC2         = 24'h800000,
  parameter logic [ACC_W-1:0] INC3         = 24'h400000,
  parameter int               LOCK_STROBES = 16,
  parameter logic [1:0]       DEFAULT_MODE = 2'd0
) (
  input  logic       sysClock,
  input  logic       reset,
  input  logic [1:0] mode_sel,
  input  logic       mode_req,
  output logic       mode_ack,
  output logic [1:0] cur_mode,
  output logic       pix_stb,
  output logic       clk_pixel_locked,
  output logic       mode_err
);

  localparam int CNT_W = (LOCK_STROBES > 1) ? $clog2(LOCK_STROBES) : 1;
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STROBES - 1);

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    SWITCH = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] inc;
  logic [ACC_W:0]   acc_sum;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       req_mode;
  logic             lock_done;

  function automatic logic [ACC_W-1:0] inc_of(input logic [1:0] m);
    case (m)
      2'd0:    inc_of = INC0;
      2'd1:    inc_of = INC1;
      2'd2:    inc_of = INC2;
      default: inc_of = INC3;
    endcase
  endfunction

  // One bit wider than the accumulator so the MSB is the carry (strobe).
  assign acc_sum = {1'b0, acc} + {1'b0, inc};

  // The strobe currently on the output is the last one needed for lock.
  assign lock_done = pix_stb && (lock_cnt == LOCK_LAST);

  always_comb begin
    state_nxt = state;
    mode_ack  = 1'b0;
    case (state)
      SETTLE: begin
        // A request wins over a simultaneous lock; the new mode re-locks anyway.
        if (mode_req) begin
          state_nxt = SWITCH;
        end else if (lock_done) begin
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (mode_req) begin
          state_nxt = SWITCH;
        end
      end
      SWITCH: begin
        mode_ack  = 1'b1;
        state_nxt = SETTLE;
      end
      default: begin
        state_nxt = SETTLE;
      end
    endcase
  end

  always_ff @(posedge sysClock or negedge reset) begin
    if (!reset) begin
      state            <= SETTLE;
      acc              <= '0;
      inc              <= inc_of(DEFAULT_MODE);
      pix_stb          <= 1'b0;
      lock_cnt         <= '0;
      clk_pixel_locked <= 1'b0;
      cur_mode         <= DEFAULT_MODE;
      req_mode         <= DEFAULT_MODE;
      mode_err         <= 1'b0;
    end else begin
      state            <= state_nxt;
      // Registered from the next state, so lock drops on the same edge that
      // enters SWITCH and rises on the edge that enters LOCKED.
      clk_pixel_locked <= (state_nxt == LOCKED);

      if (state == SWITCH) begin
        acc      <= '0;
        pix_stb  <= 1'b0;
        lock_cnt <= '0;
        cur_mode <= req_mode;
        inc      <= inc_of(req_mode);
        mode_err <= (inc_of(req_mode) == '0);
      end else begin
        acc     <= acc_sum[ACC_W-1:0];
        pix_stb <= acc_sum[ACC_W];
        if ((state == SETTLE) && pix_stb) begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end
        // Capture the requested mode when the request is accepted; the
        // requester may release mode_req/mode_sel during the ack cycle.
        if (state_nxt == SWITCH) begin
          req_mode <= mode_sel;
        end
      end
    end
  end

endmodule
